time_display: RTL

Downstream consumer of the game countdown/stopwatch timer. It converts the 14-bit binary time value to four BCD digits with a sequential double-dabble converter, and drives four active-low 7-segment digits. It blanks the display in menu, blinks the digits in the final seconds of a countdown mode, and holds a steady display once the game ends.

---
 rtl/time_display_if.sv | 26 ++
 rtl/time_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/time_display_if.sv
// Timer-to-display bus: binary time and game status in,
// four 7-segment digits plus warn/busy status out.
interface time_display_if #(
  parameter int CONV_BITS = 14
);
  logic [CONV_BITS-1:0] count_time;
  logic                 end_game;
  logic                 menu_or_game;
  logic [1:0]           mode;
  logic [6:0]           hex0;
  logic [6:0]           hex1;
  logic [6:0]           hex2;
  logic [6:0]           hex3;
  logic                 warn;
  logic                 busy;

  modport master (
    output count_time, end_game, menu_or_game, mode,
    input  hex0, hex1, hex2, hex3, warn, busy
  );

  modport slave (
    input  count_time, end_game, menu_or_game, mode,
    output hex0, hex1, hex2, hex3, warn, busy
  );
endinterface

// File: rtl/time_display.sv
// Binary timer to 4-digit 7-segment display via sequential double-dabble.
// Define TIME_DISPLAY_LZB_EN to blank leading zeros on hex3..hex1.
module time_display #(
  parameter int CONV_BITS   = 14,
  parameter int WARN_THRESH = 10,
  parameter int BLINK_HALF  = 6250000
) (
  input logic     clk,
  input logic     rst,
  time_display_if.slave bus
);
  localparam int SW = CONV_BITS + 20;
  localparam int CW = $clog2(CONV_BITS);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t               state, nxt;
  logic [SW-1:0]        sh, sh_adj;
  logic [CONV_BITS-1:0] last;
  logic [CW-1:0]        bit_cnt;
  logic [3:0][3:0]      dig;
  logic                 busy_q;
  logic [3:0][6:0]      hex_q, dec;
  logic                 warn_q;
  logic [BW-1:0]        blk_cnt;
  logic                 phase;
  logic [15:0]          val;
  logic                 in_warn;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < 5; i++) begin
      if (sh[CONV_BITS+4*i +: 4] >= 4'd5)
        sh_adj[CONV_BITS+4*i +: 4] =
          sh[CONV_BITS+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.count_time != last) nxt = SHIFT;
      SHIFT:
        if (bit_cnt == CW'(CONV_BITS - 1)) nxt = LATCH;
      LATCH:
        nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      last    <= '0;
      bit_cnt <= '0;
      dig     <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.count_time != last) begin
            sh      <= {20'd0, bus.count_time};
            last    <= bus.count_time;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
          end
        SHIFT: begin
          sh      <= {sh_adj[SW-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        LATCH: begin
          // Five BCD digits fit the input; anything past 9999 clips.
          if (sh[SW-1 -: 4] != 4'd0)
            dig <= {4'd9, 4'd9, 4'd9, 4'd9};
          else
            dig <= sh[CONV_BITS +: 16];
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    val = 16'(dig[3]) * 16'd1000 + 16'(dig[2]) * 16'd100
        + 16'(dig[1]) * 16'd10 + 16'(dig[0]);
    in_warn = !bus.mode[1] && (val != 16'd0)
            && (val <= 16'(WARN_THRESH));
    for (int i = 0; i < 4; i++) dec[i] = seg7(dig[i]);
`ifdef TIME_DISPLAY_LZB_EN
    if (dig[3] == 4'd0) dec[3] = 7'h7F;
    if (dig[3:2] == 8'd0) dec[2] = 7'h7F;
    if (dig[3:1] == 12'd0) dec[1] = 7'h7F;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q   <= {4{7'h7F}};
      warn_q  <= 1'b0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (bus.menu_or_game) begin
      hex_q   <= {4{7'h7F}};
      warn_q  <= 1'b0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (bus.end_game) begin
      hex_q   <= dec;
      warn_q  <= 1'b0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (in_warn) begin
      warn_q <= 1'b1;
      hex_q  <= phase ? {4{7'h7F}} : dec;
      if (blk_cnt == BW'(BLINK_HALF - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end else begin
      hex_q   <= dec;
      warn_q  <= 1'b0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end
  end

  assign bus.hex0 = hex_q[0];
  assign bus.hex1 = hex_q[1];
  assign bus.hex2 = hex_q[2];
  assign bus.hex3 = hex_q[3];
  assign bus.warn = warn_q;
  assign bus.busy = busy_q;
endmodule
